// File: rtl/mux_sel_arbiter_if.sv
// rtl/mux_sel_arbiter_if.sv - request/grant/select bundle between requesters and the mux select arbiter
interface mux_sel_arbiter_if;
    logic req_a;
    logic req_b;
    logic gnt_a;
    logic gnt_b;
    logic x;
    logic busy;

    modport master (
        output req_a,
        output req_b,
        input  gnt_a,
        input  gnt_b,
        input  x,
        input  busy
    );

    modport slave (
        input  req_a,
        input  req_b,
        output gnt_a,
        output gnt_b,
        output x,
        output busy
    );
endinterface

// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - two-way round-robin arbiter with hold limit driving a 1-bit mux select
module mux_sel_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    mux_sel_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_a_q, last_a_d;
    logic             x_q, x_d;
    logic             gnt_a_q, gnt_a_d;
    logic             gnt_b_q, gnt_b_d;
    logic             busy_q, busy_d;

    logic req_a;
    logic req_b;
    logic cnt_sat;
    logic entering;

    assign req_a   = bus.req_a;
    assign req_b   = bus.req_b;
    assign cnt_sat = (cnt_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_a && req_b) begin
                    state_d = last_a_q ? GNT_B : GNT_A;
                end else if (req_a) begin
                    state_d = GNT_A;
                end else if (req_b) begin
                    state_d = GNT_B;
                end
            end
            GNT_A: begin
                if (!req_a) begin
                    state_d = req_b ? GNT_B : IDLE;
                end else if (req_b && cnt_sat) begin
                    state_d = GNT_B;
                end
            end
            GNT_B: begin
                if (!req_b) begin
                    state_d = req_a ? GNT_A : IDLE;
                end else if (req_a && cnt_sat) begin
                    state_d = GNT_A;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new tenure restarts the hold count; x only moves with a grant so it stays put through IDLE.
    always_comb begin
        cnt_d    = cnt_q;
        last_a_d = last_a_q;
        x_d      = x_q;
        entering = (state_d != state_q) && (state_d != IDLE);
        if (entering) begin
            cnt_d    = '0;
            last_a_d = (state_d == GNT_A);
            x_d      = (state_d == GNT_A);
        end else if ((state_d != IDLE) && !cnt_sat) begin
            cnt_d = cnt_q + 1'b1;
        end
        gnt_a_d = (state_d == GNT_A);
        gnt_b_d = (state_d == GNT_B);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_a_q <= 1'b0;
            x_q      <= 1'b0;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_a_q <= last_a_d;
            x_q      <= x_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(gnt_a_q && gnt_b_q));
        end
    end

    assign bus.gnt_a = gnt_a_q;
    assign bus.gnt_b = gnt_b_q;
    assign bus.x     = x_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb/tb_mux_sel_arbiter.sv - self-checking bench for mux_sel_arbiter at MAX_HOLD 8 and 1
module tb_mux_sel_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mux_sel_arbiter_if if8 ();
    mux_sel_arbiter_if if1 ();

    mux_sel_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut8 (.clk(clk), .reset(reset), .bus(if8.slave));
    mux_sel_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: owner 0 none / 1 A / 2 B, run = cycles the owner has held so far.
    int owner [2];
    int run   [2];
    int last  [2];
    int mx    [2];
    int mhv   [2] = '{8, 1};

    typedef struct {
        bit rst;
        bit a;
        bit b;
        bit ga;
        bit gb;
        bit x;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input int k, input bit r, input bit a, input bit b);
        int nxt;
        if (r) begin
            owner[k] = 0; run[k] = 0; last[k] = 2; mx[k] = 0;
            return;
        end
        nxt = owner[k];
        case (owner[k])
            0: begin
                if (a && b)  nxt = (last[k] == 1) ? 2 : 1;
                else if (a)  nxt = 1;
                else if (b)  nxt = 2;
            end
            1: begin
                if (!a)                         nxt = b ? 2 : 0;
                else if (b && run[k] >= mhv[k]) nxt = 2;
            end
            default: begin
                if (!b)                         nxt = a ? 1 : 0;
                else if (a && run[k] >= mhv[k]) nxt = 1;
            end
        endcase
        if (nxt != 0 && nxt != owner[k]) begin
            run[k] = 1; last[k] = nxt; mx[k] = (nxt == 1) ? 1 : 0;
        end else if (nxt != 0) begin
            run[k]++;
        end
        owner[k] = nxt;
    endtask

    task automatic check_dut(input int k, input bit ga, input bit gb, input bit xx, input bit bz);
        string p;
        p = (k == 0) ? "mh8" : "mh1";
        check({p, " gnt_a"}, int'(ga), (owner[k] == 1) ? 1 : 0);
        check({p, " gnt_b"}, int'(gb), (owner[k] == 2) ? 1 : 0);
        check({p, " x"},     int'(xx), mx[k]);
        check({p, " busy"},  int'(bz), (owner[k] != 0) ? 1 : 0);
        check({p, " onehot"}, int'(ga & gb), 0);
    endtask

    task automatic step(input bit r, input bit a, input bit b);
        @(negedge clk);
        reset = r;
        if8.req_a = a; if8.req_b = b;
        if1.req_a = a; if1.req_b = b;
        @(posedge clk);
        model_step(0, r, a, b);
        model_step(1, r, a, b);
        #1;
        check_dut(0, if8.gnt_a, if8.gnt_b, if8.x, if8.busy);
        check_dut(1, if1.gnt_a, if1.gnt_b, if1.x, if1.busy);
    endtask

    vec_t vt [11];

    initial begin
        reset = 1'b1;
        if8.req_a = 1'b0; if8.req_b = 1'b0;
        if1.req_a = 1'b0; if1.req_b = 1'b0;
        for (int k = 0; k < 2; k++) begin
            owner[k] = 0; run[k] = 0; last[k] = 2; mx[k] = 0;
        end

        vt[0]  = '{1, 1, 1, 0, 0, 0};
        vt[1]  = '{1, 1, 1, 0, 0, 0};
        vt[2]  = '{0, 1, 1, 1, 0, 1};
        vt[3]  = '{0, 0, 1, 0, 1, 0};
        vt[4]  = '{0, 0, 1, 0, 1, 0};
        vt[5]  = '{0, 0, 0, 0, 0, 0};
        vt[6]  = '{0, 1, 0, 1, 0, 1};
        vt[7]  = '{0, 0, 0, 0, 0, 1};
        vt[8]  = '{0, 1, 1, 0, 1, 0};
        vt[9]  = '{1, 1, 1, 0, 0, 0};
        vt[10] = '{0, 1, 1, 1, 0, 1};
        for (int i = 0; i < 11; i++) begin
            step(vt[i].rst, vt[i].a, vt[i].b);
            check($sformatf("vec%0d mh8 gnt_a", i), int'(if8.gnt_a), int'(vt[i].ga));
            check($sformatf("vec%0d mh8 gnt_b", i), int'(if8.gnt_b), int'(vt[i].gb));
            check($sformatf("vec%0d mh8 x", i),     int'(if8.x),     int'(vt[i].x));
            check($sformatf("vec%0d mh1 gnt_a", i), int'(if1.gnt_a), int'(vt[i].ga));
            check($sformatf("vec%0d mh1 gnt_b", i), int'(if1.gnt_b), int'(vt[i].gb));
            check($sformatf("vec%0d mh1 x", i),     int'(if1.x),     int'(vt[i].x));
        end

        // Single requester B for 5 cycles, then idle with x left at 0.
        step(1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1);
            check($sformatf("single%0d gnt_b", i), int'(if8.gnt_b), 1);
        end
        step(0, 0, 0);
        check("single idle busy", int'(if8.busy), 0);
        check("single idle x", int'(if8.x), 0);

        // Continuous contention from IDLE: tenures of exactly MAX_HOLD cycles.
        step(1, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 1);
            check($sformatf("fair8 c%0d gnt_a", i), int'(if8.gnt_a), ((i / 8) % 2 == 0) ? 1 : 0);
            check($sformatf("fair8 c%0d busy", i),  int'(if8.busy), 1);
            check($sformatf("fair1 c%0d gnt_a", i), int'(if1.gnt_a), (i % 2 == 0) ? 1 : 0);
        end

        // Late contender after A saturates the hold count.
        step(1, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 0);
        step(0, 1, 1);
        check("late mh8 gnt_b", int'(if8.gnt_b), 1);
        check("late mh1 gnt_b", int'(if1.gnt_b), 1);
        // Direct handoff back to A when B drops.
        step(0, 1, 0);
        check("handoff gnt_a", int'(if8.gnt_a), 1);
        check("handoff busy", int'(if8.busy), 1);

        // Reset in the third cycle of a B tenure, then A wins the tie.
        step(1, 0, 0);
        step(0, 0, 1);
        step(0, 1, 1);
        step(0, 1, 1);
        step(1, 1, 1);
        check("midreset busy", int'(if8.busy), 0);
        step(0, 1, 1);
        check("midreset mh8 a first", int'(if8.gnt_a), 1);
        check("midreset mh1 a first", int'(if1.gnt_a), 1);
        step(0, 1, 1);
        check("midreset mh1 toggle", int'(if1.gnt_b), 1);

        // Randomized phase with varying request bias and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bit r, a, b;
            bias = (i / 500) % 3;
            r = ($urandom_range(0, 199) == 0);
            a = ($urandom_range(0, 3) < 1 + bias);
            b = ($urandom_range(0, 3) < 3 - bias);
            step(r, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
